instr_rx: RTL and testbench

INSTR_RX -- requirements
Module: instr_rx

---
 rtl/instr_rx_if.sv | 35 +++
 rtl/instr_rx.sv | 142 ++++++++++++++
 tb/tb_instr_rx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_rx_if.sv
// rtl/instr_rx_if.sv - instruction receive/decode handshake bundle
// master: instruction driver and decoded-field consumer; slave: instr_rx
interface instr_rx_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_instr;
  logic                     out_valid;
  logic                     out_ready;
  logic [6:0]               out_opcode;
  logic [4:0]               out_rd;
  logic [4:0]               out_rs1;
  logic [4:0]               out_rs2;
  logic [2:0]               out_funct3;
  logic [6:0]               out_funct7;
  logic [31:0]              out_imm;
  logic [2:0]               out_fmt;
  logic                     out_illegal;
  logic [$clog2(DEPTH):0]   level;
  logic [CNT_W-1:0]         count;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_illegal, level, count
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_illegal, level, count
  );
endinterface

// File: rtl/instr_rx.sv
// rtl/instr_rx.sv - RV32I instruction FIFO with decode-at-push and registered head fields
// Optional INSTR_RX_ILLEGAL_DROP_EN: accept and count illegal words but do not enqueue them.
module instr_rx #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  instr_rx_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_X = 3'd7;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec;
  entry_t          head;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [LW-1:0]   lvl;
  logic [CNT_W-1:0] cnt;
  logic            up;
  logic            accept;
  logic            enq;
  logic            pop;
  logic [31:0]     w;

  assign w = bus.in_instr;

  always_comb begin
    dec         = '0;
    dec.opcode  = w[6:0];
    dec.rd      = w[11:7];
    dec.funct3  = w[14:12];
    dec.rs1     = w[19:15];
    dec.rs2     = w[24:20];
    dec.funct7  = w[31:25];
    case (w[6:0])
      7'b0110011: dec.fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec.fmt = FMT_I;
        dec.imm = {{20{w[31]}}, w[31:20]};
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = {{20{w[31]}}, w[31:25], w[11:7]};
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        dec.imm = {w[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        dec.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      end
      default: begin
        dec.fmt     = FMT_X;
        dec.illegal = 1'b1;
      end
    endcase
  end

  // `up` keeps in_ready low through reset and for the release edge itself
  assign bus.in_ready  = up && (lvl != LW'(DEPTH));
  assign bus.out_valid = (lvl != '0);
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
`ifdef INSTR_RX_ILLEGAL_DROP_EN
  assign enq           = accept && !dec.illegal;
`else
  assign enq           = accept;
`endif

  always_ff @(posedge clk) begin
    if (enq) mem[wptr] <= dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
      cnt  <= '0;
      up   <= 1'b0;
    end else begin
      up <= 1'b1;
      if (enq) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      if (accept) cnt <= cnt + CNT_W'(1);
      case ({enq, pop})
        2'b10:   lvl <= lvl + LW'(1);
        2'b01:   lvl <= lvl - LW'(1);
        default: lvl <= lvl;
      endcase
    end
  end

  // Empty (including reset) presents all-zero fields rather than stale storage
  always_comb begin
    head = '0;
    if (bus.out_valid) head = mem[rptr];
  end

  assign bus.out_opcode = head.opcode;
  assign bus.out_rd     = head.rd;
  assign bus.out_rs1    = head.rs1;
  assign bus.out_rs2    = head.rs2;
  assign bus.out_funct3 = head.funct3;
  assign bus.out_funct7 = head.funct7;
  assign bus.out_imm    = head.imm;
  assign bus.out_fmt    = head.fmt;
`ifdef INSTR_RX_ILLEGAL_DROP_EN
  assign bus.out_illegal = 1'b0;
`else
  assign bus.out_illegal = head.illegal;
`endif
  assign bus.level = lvl;
  assign bus.count = cnt;
endmodule

// File: tb/tb_instr_rx.sv
// tb/tb_instr_rx.sv - directed self-checking bench for instr_rx (DEPTH=4, CNT_W=16)
module tb_instr_rx;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  instr_rx_if #(.DEPTH(4), .CNT_W(16)) bus ();

  instr_rx #(.DEPTH(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi_imm(input int v);
    return (32'(v) << 20) | 32'h0000_0093;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int got;
    logic acc;
    n_checks = 0;
    n_err    = 0;

    // reset state, in_valid during reset ignored
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0050_0093;
    bus.out_ready = 1'b0;
    #2;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_level", bus.level, 0);
    check("rst_imm", bus.out_imm, 0);
    tick();
    tick();
    check("rst_count_ignored", bus.count, 0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    check("release_in_ready_low", bus.in_ready, 0);
    tick();
    check("release_in_ready_high", bus.in_ready, 1);
    check("release_count", bus.count, 0);

    // single I-type push
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0050_0093;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("i_valid", bus.out_valid, 1);
    check("i_opcode", bus.out_opcode, 7'h13);
    check("i_rd", bus.out_rd, 1);
    check("i_rs1", bus.out_rs1, 0);
    check("i_imm", bus.out_imm, 5);
    check("i_fmt", bus.out_fmt, 1);
    check("i_count", bus.count, 1);
    tick();
    check("i_popped", bus.out_valid, 0);

    // S then B, with hold while out_ready=0
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0020_A423;
    tick();
    bus.in_instr = 32'hFE00_0EE3;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("s_level", bus.level, 2);
    check("s_fmt", bus.out_fmt, 2);
    check("s_rs1", bus.out_rs1, 1);
    check("s_rs2", bus.out_rs2, 2);
    check("s_imm", bus.out_imm, 8);
    check("s_funct3", bus.out_funct3, 2);
    bus.out_ready = 1'b1;
    tick();
    check("b_fmt", bus.out_fmt, 3);
    check("b_imm", bus.out_imm, 32'hFFFF_FFFC);
    check("b_illegal", bus.out_illegal, 0);
    tick();
    check("sb_empty", bus.out_valid, 0);
    check("sb_count", bus.count, 3);

    // fill to full, 5th word held, then drain in order
    bus.out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = addi_imm(k + 1);
      acc = bus.in_ready;
      tick();
      if (acc) k++;
    end
    check("full_accepted", k, 4);
    check("full_level", bus.level, 4);
    check("full_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    check("full_blocks_with_out_ready", bus.in_ready, 0);
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (k < 5) begin
        bus.in_valid = 1'b1;
        bus.in_instr = addi_imm(k + 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        check($sformatf("drain_order%0d", got), bus.out_imm, 64'(got + 1));
        got++;
      end
      tick();
      if (acc) k++;
    end
    bus.in_valid = 1'b0;
    check("drain_all", got, 5);
    check("drain_level", bus.level, 0);
    check("drain_count", bus.count, 8);

    // illegal opcode
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'hFFFF_FFFF;
    tick();
    bus.in_valid = 1'b0;
    check("ill_count", bus.count, 9);
`ifdef INSTR_RX_ILLEGAL_DROP_EN
    check("ill_dropped", bus.out_valid, 0);
    check("ill_level", bus.level, 0);
`else
    check("ill_valid", bus.out_valid, 1);
    check("ill_flag", bus.out_illegal, 1);
    check("ill_fmt", bus.out_fmt, 7);
    check("ill_imm", bus.out_imm, 0);
    check("ill_opcode", bus.out_opcode, 7'h7F);
    bus.out_ready = 1'b1;
    tick();
    check("ill_popped", bus.out_valid, 0);
`endif

    // asynchronous reset mid-burst at level 3
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = addi_imm(c + 1);
      tick();
    end
    check("burst_level", bus.level, 3);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", bus.out_valid, 0);
    check("async_level", bus.level, 0);
    check("async_count", bus.count, 0);
    check("async_in_ready", bus.in_ready, 0);
    check("async_imm", bus.out_imm, 0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0070_0113;
    tick();
    bus.in_valid = 1'b0;
    check("post_rst_level", bus.level, 1);
    check("post_rst_count", bus.count, 1);
    check("post_rst_rd", bus.out_rd, 2);
    check("post_rst_imm", bus.out_imm, 7);
    bus.out_ready = 1'b1;
    tick();
    check("post_rst_alone", bus.out_valid, 0);

    // steady push+pop at level 2 across pointer wrap
    bus.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = addi_imm(100 + c);
      tick();
    end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = addi_imm(102 + j);
      check($sformatf("steady_level%0d", j), bus.level, 2);
      check($sformatf("steady_order%0d", j), bus.out_imm, 64'(100 + j));
      tick();
    end
    bus.in_valid = 1'b0;
    check("steady_level_end", bus.level, 2);
    check("steady_count", bus.count, 23);
    check("steady_tail0", bus.out_imm, 120);
    tick();
    check("steady_tail1", bus.out_imm, 121);
    tick();
    check("steady_empty", bus.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
